// File: rtl/rob_core_if.sv
// Decode/dispatch, writeback, branch-resolve and commit signals of the reorder buffer.
//   master : decode / execution / branch side (drives dispatch, writeback, mispredict)
//   slave  : rob_core (drives rob_ready, rob_empty, DC_rob_idx and the commit bundle)
interface rob_core_if #(
    parameter int unsigned IDX_W = 4
);
    // Dispatch from decode
    logic             dispatch_valid;
    logic [31:0]      DC_pc;
    logic [31:0]      DC_inst;
    logic [6:0]       DC_P_rd_new;
    logic [6:0]       DC_P_rd_old;
    logic             DC_allocate_rd;
    logic             rob_ready;
    logic             rob_empty;
    logic [IDX_W-1:0] DC_rob_idx;
    // Completion and branch resolution
    logic             wb_valid;
    logic [IDX_W-1:0] wb_rob_idx;
    logic             mispredict;
    logic [IDX_W-1:0] br_rob_idx;
    // Retirement
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [6:0]       commit_P_rd_new;
    logic [6:0]       commit_P_rd_old;
    logic             commit_free;
    logic             commit_store;

    modport master (
        output dispatch_valid, DC_pc, DC_inst, DC_P_rd_new, DC_P_rd_old, DC_allocate_rd,
        output wb_valid, wb_rob_idx, mispredict, br_rob_idx,
        input  rob_ready, rob_empty, DC_rob_idx,
        input  commit_valid, commit_pc, commit_P_rd_new, commit_P_rd_old, commit_free,
        input  commit_store
    );

    modport slave (
        input  dispatch_valid, DC_pc, DC_inst, DC_P_rd_new, DC_P_rd_old, DC_allocate_rd,
        input  wb_valid, wb_rob_idx, mispredict, br_rob_idx,
        output rob_ready, rob_empty, DC_rob_idx,
        output commit_valid, commit_pc, commit_P_rd_new, commit_P_rd_old, commit_free,
        output commit_store
    );
endinterface

// File: rtl/rob_core.sv
// Reorder buffer: in-order dispatch (one per cycle), out-of-order completion via writeback,
// in-order retirement (one per cycle) and flush of everything younger than a mispredicted
// branch.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   rob : rob_core_if.slave -- dispatch, writeback, mispredict inputs; ready/empty/tail index
//         and the commit bundle (pc, P_rd_new, P_rd_old, free, store) outputs
module rob_core #(
    parameter int unsigned ROB_LEN = 16,
    localparam int unsigned IDX_W = $clog2(ROB_LEN)
) (
    input  logic        clk,
    input  logic        rst,
    rob_core_if.slave   rob
);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpFstore = 5'b01001;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    ptr_t head_q, head_d, tail_q, tail_d, count;
    idx_t head_idx, tail_idx, br_off;

    logic [ROB_LEN-1:0] valid_q, valid_d, done_q, done_d;
    logic [ROB_LEN-1:0] store_q, store_d, alloc_q, alloc_d;
    logic [ROB_LEN-1:0] younger;
    logic [31:0]        pc_q      [ROB_LEN];
    logic [6:0]         prd_new_q [ROB_LEN];
    logic [6:0]         prd_old_q [ROB_LEN];

    logic do_dispatch, do_wb, do_commit, dc_is_store;
    logic unused_inst;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign count    = tail_q - head_q;

    assign rob.rob_ready  = (count != ptr_t'(ROB_LEN));
    assign rob.rob_empty  = (count == '0);
    assign rob.DC_rob_idx = tail_idx;

    assign dc_is_store = (rob.DC_inst[6:2] == OpStore) || (rob.DC_inst[6:2] == OpFstore);
    assign unused_inst = ^{rob.DC_inst[31:7], rob.DC_inst[1:0]};

    // Age is the distance from head; anything farther than the branch is on the wrong path.
    assign br_off = rob.br_rob_idx - head_idx;
    always_comb begin
        younger = '0;
        for (int i = 0; i < ROB_LEN; i++) begin
            younger[i] = (idx_t'(i) - head_idx) > br_off;
        end
    end

    assign do_commit   = valid_q[head_idx] && done_q[head_idx];
    assign do_dispatch = rob.dispatch_valid && rob.rob_ready && !rob.mispredict;
    assign do_wb       = rob.wb_valid && valid_q[rob.wb_rob_idx]
                         && !(rob.mispredict && younger[rob.wb_rob_idx]);

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        store_d = store_q;
        alloc_d = alloc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (do_wb) begin
            done_d[rob.wb_rob_idx] = 1'b1;
        end
        if (do_dispatch) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            store_d[tail_idx] = dc_is_store;
            alloc_d[tail_idx] = rob.DC_allocate_rd;
            tail_d            = tail_q + ptr_t'(1);
        end
        if (rob.mispredict) begin
            valid_d = valid_d & ~younger;
            // Uses the pre-commit head so a same-cycle retirement cannot shift the new tail.
            tail_d  = head_q + ptr_t'(br_off) + ptr_t'(1);
        end
        if (do_commit) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            store_q <= '0;
            alloc_q <= '0;
            for (int i = 0; i < ROB_LEN; i++) begin
                pc_q[i]      <= '0;
                prd_new_q[i] <= '0;
                prd_old_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            store_q <= store_d;
            alloc_q <= alloc_d;
            if (do_dispatch) begin
                pc_q[tail_idx]      <= rob.DC_pc;
                prd_new_q[tail_idx] <= rob.DC_P_rd_new;
                prd_old_q[tail_idx] <= rob.DC_P_rd_old;
            end
        end
    end

    assign rob.commit_valid    = do_commit;
    assign rob.commit_pc       = pc_q[head_idx];
    assign rob.commit_P_rd_new = prd_new_q[head_idx];
    assign rob.commit_P_rd_old = prd_old_q[head_idx];
    assign rob.commit_free     = do_commit && alloc_q[head_idx];
    assign rob.commit_store    = do_commit && store_q[head_idx];
endmodule

// File: tb/tb_rob_core.sv
module tb_rob_core;
    localparam int unsigned LEN = 8;

    logic clk;
    logic rst;

    rob_core_if #(.IDX_W(3)) rob ();

    rob_core #(.ROB_LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  pn;
        logic [6:0]  po;
        logic        fr;
        logic        st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   commit_cnt = 0;
    int   tail_m     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Commit scoreboard: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rob.commit_valid) begin
                check("commit_has_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("commit_pc", rob.commit_pc, e.pc);
                    check("commit_P_rd_new", 32'(rob.commit_P_rd_new), 32'(e.pn));
                    check("commit_P_rd_old", 32'(rob.commit_P_rd_old), 32'(e.po));
                    check("commit_free", 32'(rob.commit_free), 32'(e.fr));
                    check("commit_store", 32'(rob.commit_store), 32'(e.st));
                end
                commit_cnt++;
            end else begin
                check("idle_free", 32'(rob.commit_free), 32'd0);
                check("idle_store", 32'(rob.commit_store), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rob.dispatch_valid = 1'b0;
        rob.wb_valid       = 1'b0;
        rob.mispredict     = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst, input logic [6:0] pn,
                        input logic [6:0] po, input logic al, input logic st);
        exp_t e;
        check("dc_rob_idx", 32'(rob.DC_rob_idx), 32'(tail_m % LEN));
        rob.dispatch_valid = 1'b1;
        rob.DC_pc          = pc;
        rob.DC_inst        = inst;
        rob.DC_P_rd_new    = pn;
        rob.DC_P_rd_old    = po;
        rob.DC_allocate_rd = al;
        e.pc = pc;
        e.pn = pn;
        e.po = po;
        e.fr = al;
        e.st = st;
        exp_q.push_back(e);
        tail_m++;
    endtask

    task automatic wb(input int idx);
        rob.wb_valid   = 1'b1;
        rob.wb_rob_idx = 3'(idx);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst                = 1'b1;
        rob.dispatch_valid = 1'b0;
        rob.DC_pc          = '0;
        rob.DC_inst        = '0;
        rob.DC_P_rd_new    = '0;
        rob.DC_P_rd_old    = '0;
        rob.DC_allocate_rd = 1'b0;
        rob.wb_valid       = 1'b0;
        rob.wb_rob_idx     = '0;
        rob.mispredict     = 1'b0;
        rob.br_rob_idx     = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(rob.rob_ready), 32'd1);
        check("rst_empty", 32'(rob.rob_empty), 32'd1);
        check("rst_idx", 32'(rob.DC_rob_idx), 32'd0);
        check("rst_commit_valid", 32'(rob.commit_valid), 32'd0);
        check("rst_commit_pc", rob.commit_pc, 32'd0);

        // Fill the ROB with no completions
        for (int i = 0; i < LEN; i++) begin
            check("fill_ready", 32'(rob.rob_ready), 32'd1);
            disp(32'(4 * i), 32'h13, 7'(8 + i), 7'(i), 1'b1, 1'b0);
            tick();
        end
        check("full_ready", 32'(rob.rob_ready), 32'd0);
        check("full_empty", 32'(rob.rob_empty), 32'd0);
        // Dispatch attempt while full must not move tail
        rob.dispatch_valid = 1'b1;
        rob.DC_pc          = 32'h100;
        tick();
        check("full_tail_held", 32'(rob.DC_rob_idx), 32'd0);
        check("full_ready_held", 32'(rob.rob_ready), 32'd0);

        // Out-of-order completion: 2, 1, then 0
        wb(2);
        tick();
        wb(1);
        tick();
        check("ooo_not_yet", 32'(rob.commit_valid), 32'd0);
        check("ooo_cnt0", 32'(commit_cnt), 32'd0);
        wb(0);
        tick();
        check("ooo_commit_valid", 32'(rob.commit_valid), 32'd1);
        check("ooo_full_still", 32'(rob.rob_ready), 32'd0);
        tick();
        check("ooo_ready_after_commit", 32'(rob.rob_ready), 32'd1);
        check("ooo_cnt1", 32'(commit_cnt), 32'd1);
        tick();
        tick();
        check("ooo_stop_at_3", 32'(rob.commit_valid), 32'd0);
        check("ooo_cnt3", 32'(commit_cnt), 32'd3);
        for (int i = 3; i < LEN; i++) begin
            wb(i);
            tick();
        end
        wait_drain();

        // Free / store flags
        disp(32'h200, 32'h13, 7'h40, 7'h25, 1'b1, 1'b0);
        tick();
        disp(32'h204, 32'h0011_2023, 7'h41, 7'h26, 1'b0, 1'b1);
        tick();
        disp(32'h208, 32'h0011_2027, 7'h42, 7'h27, 1'b0, 1'b1);
        tick();
        wb(0);
        tick();
        wb(1);
        tick();
        wb(2);
        tick();
        wait_drain();
        check("store_cnt", 32'(commit_cnt), 32'd11);

        // Mid-operation reset discards live entries
        disp(32'h280, 32'h13, 7'h1, 7'h2, 1'b1, 1'b0);
        tick();
        disp(32'h284, 32'h13, 7'h3, 7'h4, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tail_m = 0;
        check("mid_rst_empty", 32'(rob.rob_empty), 32'd1);
        check("mid_rst_idx", 32'(rob.DC_rob_idx), 32'd0);
        check("mid_rst_commit", 32'(rob.commit_valid), 32'd0);

        // Mispredict: head=1, tail=5, branch at idx 2
        for (int i = 0; i < 5; i++) begin
            disp(32'h300 + 32'(4 * i), 32'h13, 7'(16 + i), 7'(32 + i), 1'b1, 1'b0);
            tick();
        end
        wb(0);
        tick();
        tick();
        wb(1);
        tick();
        check("mp_head_ready", 32'(rob.commit_valid), 32'd1);
        rob.mispredict = 1'b1;
        rob.br_rob_idx = 3'd2;
        wb(4);
        // Dispatch in the same cycle must be dropped
        rob.dispatch_valid = 1'b1;
        rob.DC_pc          = 32'hDEAD;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        tail_m = 3;
        tick();
        check("mp_tail", 32'(rob.DC_rob_idx), 32'd3);
        check("mp_commit_same_cycle", 32'(commit_cnt), 32'd13);
        check("mp_empty", 32'(rob.rob_empty), 32'd0);
        disp(32'h400, 32'h13, 7'h50, 7'h51, 1'b1, 1'b0);
        tick();
        wb(2);
        tick();
        wb(3);
        tick();
        wait_drain();
        check("mp_cnt", 32'(commit_cnt), 32'd15);
        check("mp_final_idx", 32'(rob.DC_rob_idx), 32'd4);

        // Dispatch, writeback and commit every cycle across pointer wrap
        for (int i = 0; i < 3 * LEN + 2; i++) begin
            if (i < 3 * LEN) begin
                disp(32'h1000 + 32'(4 * i), 32'h13, 7'(i), 7'(64 + i), 1'(i), 1'b0);
            end
            if (i >= 1 && i <= 3 * LEN) begin
                wb((4 + i - 1) % LEN);
            end
            tick();
            if (i < 3 * LEN) begin
                check("wrap_not_empty", 32'(rob.rob_empty), 32'd0);
                check("wrap_ready", 32'(rob.rob_ready), 32'd1);
            end
        end
        wait_drain();
        check("total_commits", 32'(commit_cnt), 32'd39);
        check("end_empty", 32'(rob.rob_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rob_core.md
# rob_core

Reorder buffer that sits at the receiving end of the decode/dispatch interface. Accepts one in-order instruction per cycle from the decode stage, returns the allocated ROB index, records out-of-order completion from the writeback buses, and retires one instruction per cycle in program order. Retirement releases the old physical destination to the free list and retires stores to the store queue. On a branch mispredict it discards every entry younger than the branch.

## Interface
- ROB_LEN, 16, number of entries; power of two, ≥ 4; IDX_W = $clog2(ROB_LEN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dispatch_valid  in  1  decode presents an instruction; decode already qualifies it with rob_ready
- DC_pc  in  32  instruction PC
- DC_inst  in  32  raw instruction; opcode field inst[6:2] marks a store when it equals `S_TYPE or `FSTORE
- DC_P_rd_new  in  7  newly allocated physical destination
- DC_P_rd_old  in  7  previous mapping of the architectural destination
- DC_allocate_rd  in  1  instruction allocated a physical destination
- rob_ready  out  1  at least one free entry
- rob_empty  out  1  no valid entries
- DC_rob_idx  out  IDX_W  index that the current dispatch will occupy (tail)
- wb_valid  in  1  an execution unit completed
- wb_rob_idx  in  IDX_W  index of the completed instruction
- mispredict  in  1  the branch at br_rob_idx resolved mispredicted
- br_rob_idx  in  IDX_W  ROB index of the mispredicted branch
- commit_valid  out  1  head instruction retires this cycle
- commit_pc  out  32  PC of the retiring instruction
- commit_P_rd_new  out  7  physical destination of the retiring instruction
- commit_P_rd_old  out  7  physical register to release
- commit_free  out  1  commit_valid and the entry allocated a destination
- commit_store  out  1  commit_valid and the entry is a store

## Operation
- Per-entry state: valid, done, is_store, alloc_rd, pc, P_rd_new, P_rd_old.
- head and tail pointers are IDX_W+1 bits; the extra bit disambiguates full from empty. count = tail − head.
- Dispatch: when dispatch_valid && rob_ready && !mispredict, write the tail entry with valid=1, done=0, and is_store decoded from DC_inst[6:2]. Then tail increments.
- Writeback: when wb_valid && valid[wb_rob_idx], set done. Writeback to an invalid entry is ignored.
- Commit: commit_valid = valid[head] && done[head]. It is combinational from registered state. On commit, clear valid[head] and increment head.
- Mispredict: clear valid on all entries strictly younger than br_rob_idx. Then tail = head + ((br_rob_idx − head[IDX_W-1:0]) mod ROB_LEN) + 1, computed using head as it was before any same-cycle commit.
- Priority within one cycle:
  - Mispredict overrides dispatch; the dispatch is dropped.
  - Commit of the head is still performed during a mispredict.
  - Writeback to an entry being flushed is discarded.
  - Writeback to the head in the same cycle does not make it committable until the next cycle.
- Pointers wrap modulo 2·ROB_LEN; indices use the low IDX_W bits.

## Timing
- Reset: head=tail=0, all valid=0, done=0.
  - Outputs: rob_ready=1, rob_empty=1, DC_rob_idx=0, commit_valid=0, commit_free=0, commit_store=0.
  - Other commit outputs are 0 (entry payloads reset to 0).
- rob_ready = (count != ROB_LEN); rob_empty = (count == 0). Both are registered-state functions with no combinational path from inputs.
- Dispatch is written at edge N. The entry is visible at N+1; a writeback can arrive at N+1 at the earliest. Commit is possible at N+2.
- Throughput: one dispatch, one writeback, and one commit per cycle, concurrently.
- Full ROB: rob_ready=0. A commit that cycle frees one entry, so rob_ready=1 at the next cycle. There is no same-cycle bypass.
- Reset asserted mid-operation discards all entries on that edge.

## Test plan
- Reset: hold rst 2 cycles -> rob_ready=1, rob_empty=1, DC_rob_idx=0, commit_valid=0.
- Fill (ROB_LEN=4): dispatch 4 instructions (PC 0x0,4,8,C) with no writeback -> rob_ready=0 after the 4th edge. A 5th dispatch_valid does not change tail.
- Out-of-order writeback: entries 0..3 live; write back idx 2, then 1, then 0 -> commits PC 0x0,4,8 on consecutive cycles starting the cycle after idx 0's writeback. Commit stops at idx 3.
- Free/store flags: commit an entry with DC_allocate_rd=1, P_rd_old=0x25 -> commit_free=1, commit_P_rd_old=0x25. Commit a store (inst[6:2]=`S_TYPE) -> commit_store=1, commit_free=0.
- Mispredict: head=1, tail=5 (ROB_LEN=8), mispredict with br_rob_idx=2 -> tail=3, entries 3,4 invalid. A writeback to idx 4 the same cycle is ignored. The next dispatch gets DC_rob_idx=3.
- Wrap and simultaneous events: run 3·ROB_LEN instructions with dispatch, writeback and commit every cycle -> PCs commit in order across pointer wrap, count stays constant, and rob_empty never asserts.
